// File: rtl/sb_pkg.sv
// Shared sideband constants and types. The framing and serializer stages both
// use them, so phase width and dead time are defined in one place.
package sb_pkg;

    localparam int SB_PKT_W  = 64;
    localparam int SB_GAP_UI = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } sb_ser_state_e;

endpackage

// File: rtl/sb_tx_serializer_if.sv
// Link between the sideband framing stage (master) and the TX serializer (slave),
// plus the serial lane outputs.
interface sb_tx_serializer_if #(
    parameter int PKT_W = sb_pkg::SB_PKT_W
);

    // Handshake: a phase transfers on a rising clock edge where i_packet_valid=1
    // and o_ser_done=1 (ready). The master holds i_packet and i_packet_valid
    // stable until that edge. Valid without ready has no effect.
    logic [PKT_W-1:0] i_packet;
    logic             i_packet_valid;
    logic             o_ser_done;
    logic             o_txdata;
    logic             o_clk_en;

    modport master (
        output i_packet,
        output i_packet_valid,
        input  o_ser_done,
        input  o_txdata,
        input  o_clk_en
    );

    modport slave (
        input  i_packet,
        input  i_packet_valid,
        output o_ser_done,
        output o_txdata,
        output o_clk_en
    );

endinterface

// File: rtl/sb_tx_serializer.sv
// Sideband TX serializer. Shifts one framed phase out LSB-first at one bit per
// clock, then holds the lane low for the mandatory dead time before taking the next phase.
module sb_tx_serializer
    import sb_pkg::*;
#(
    parameter int PKT_W  = SB_PKT_W,
    parameter int GAP_UI = SB_GAP_UI
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    sb_tx_serializer_if.slave sb,
    output sb_ser_state_e     o_state
);

    localparam int BIT_W = $clog2(PKT_W);
    localparam int GAP_W = $clog2(GAP_UI);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PKT_W - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_UI - 1);

    sb_ser_state_e    state_q, state_d;
    logic [PKT_W-1:0] shift_q, shift_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             txdata_q, txdata_d;
    logic             clk_en_q, clk_en_d;
    logic             ser_done_q, ser_done_d;
    logic             load;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            txdata_q   <= 1'b0;
            clk_en_q   <= 1'b0;
            ser_done_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            txdata_q   <= txdata_d;
            clk_en_q   <= clk_en_d;
            ser_done_q <= ser_done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        txdata_d  = 1'b0;
        clk_en_d  = 1'b0;
        load      = 1'b0;

        case (state_q)
            IDLE: begin
                load = sb.i_packet_valid;
            end
            SHIFT: begin
                // Lane output is registered, so it trails the state by one cycle.
                txdata_d = shift_q[0];
                clk_en_d = 1'b1;
                shift_d  = shift_q >> 1;
                if (bit_cnt_q == BIT_LAST) begin
                    state_d   = GAP;
                    gap_cnt_d = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    load = sb.i_packet_valid;
                    if (!sb.i_packet_valid) begin
                        state_d = IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            shift_d   = sb.i_packet;
            bit_cnt_d = '0;
            state_d   = SHIFT;
        end

        // Ready is derived from the next state so it is high exactly while the
        // registered state is IDLE or on the last dead-time cycle.
        ser_done_d = (state_d == IDLE) || ((state_d == GAP) && (gap_cnt_d == GAP_LAST));
    end

    assign sb.o_ser_done = ser_done_q;
    assign sb.o_txdata   = txdata_q;
    assign sb.o_clk_en   = clk_en_q;
    assign o_state       = state_q;

endmodule

// File: tb/tb_sb_tx_serializer.sv
// Bench for sb_tx_serializer: a timeline reference model predicts every lane
// cycle, and a word-level scoreboard checks each reassembled phase.
module tb_sb_tx_serializer;
    import sb_pkg::*;

    localparam int PKT_W  = SB_PKT_W;
    localparam int GAP_UI = SB_GAP_UI;
    localparam int PERIOD = PKT_W + GAP_UI;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    sb_ser_state_e dbg_state;

    sb_tx_serializer_if #(.PKT_W(PKT_W)) sb ();

    sb_tx_serializer #(.PKT_W(PKT_W), .GAP_UI(GAP_UI)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .sb      (sb),
        .o_state (dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the edge on which the current phase was loaded, and its data.
    int               cyc = 0;
    int               load_edge = -1;
    int               accepts = 0;
    logic [PKT_W-1:0] model_pkt = '0;

    // Scoreboard: accepted phases waiting to be seen on the lane.
    logic [PKT_W-1:0] exp_q[$];
    logic [PKT_W-1:0] mon_word = '0;
    logic [PKT_W-1:0] last_word = '0;
    int               mon_bits = 0;
    int               words_done = 0;

    typedef struct {
        logic [PKT_W-1:0] pkt;
        int               pre_idle;
        logic [PKT_W-1:0] exp_word;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // After edge c: bit i of the phase loaded at edge L is on the lane after edge L+1+i;
    // ready comes back on the last dead-time cycle (edge L+PERIOD-1) and stays up.
    function automatic void model_out(input int c, output logic tx, output logic ce, output logic done);
        int d;
        tx   = 1'b0;
        ce   = 1'b0;
        done = 1'b1;
        if (load_edge >= 0) begin
            d = c - load_edge;
            if (d >= 1 && d <= PKT_W) begin
                tx = model_pkt[d-1];
                ce = 1'b1;
            end
            done = (d >= PERIOD - 1);
        end
    endfunction

    task automatic step();
        logic tx, ce, done, pdone;
        model_out(cyc, tx, ce, pdone);
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            load_edge = -1;
        end else if (sb.i_packet_valid && pdone) begin
            load_edge = cyc;
            model_pkt = sb.i_packet;
            exp_q.push_back(sb.i_packet);
            accepts++;
        end
        @(negedge clk);
        model_out(cyc, tx, ce, done);
        check("txdata", sb.o_txdata, tx);
        check("clk_en", sb.o_clk_en, ce);
        check("ser_done", sb.o_ser_done, done);
        if (sb.o_clk_en === 1'b1) begin
            mon_word = {sb.o_txdata, mon_word[PKT_W-1:1]};
            mon_bits++;
            if (mon_bits == PKT_W) begin
                mon_bits = 0;
                words_done++;
                last_word = mon_word;
                check("word_expected", (exp_q.size() > 0), 1'b1);
                if (exp_q.size() > 0) check("word", mon_word, exp_q.pop_front());
            end
        end
    endtask

    task automatic wait_accept();
        int start;
        int n;
        start = accepts;
        n = 0;
        while (accepts == start && n < 4 * PERIOD) begin
            step();
            n++;
        end
    endtask

    task automatic wait_word(input string name);
        int start;
        int n;
        start = words_done;
        n = 0;
        while (words_done == start && n < 4 * PERIOD) begin
            step();
            n++;
        end
        check(name, (words_done > start), 1'b1);
    endtask

    task automatic send_phase(input logic [PKT_W-1:0] pkt, input int pre_idle);
        sb.i_packet_valid = 1'b0;
        for (int i = 0; i < pre_idle; i++) step();
        sb.i_packet       = pkt;
        sb.i_packet_valid = 1'b1;
        wait_accept();
        sb.i_packet_valid = 1'b0;
        sb.i_packet       = {$urandom, $urandom};
    endtask

    task automatic async_reset(input int hold);
        #2;
        rst_n = 1'b0;
        #1;
        load_edge = -1;
        mon_bits  = 0;
        exp_q.delete();
        check("rst_txdata", sb.o_txdata, 1'b0);
        check("rst_clk_en", sb.o_clk_en, 1'b0);
        check("rst_ser_done", sb.o_ser_done, 1'b1);
        check("rst_state", dbg_state, IDLE);
        for (int i = 0; i < hold; i++) step();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fall_cyc;
        int rise_cyc;
        logic prev_ce;

        sb.i_packet       = '0;
        sb.i_packet_valid = 1'b0;

        vecs[0] = '{pkt: 64'h8000_0000_0000_0001, pre_idle: 0, exp_word: 64'h8000_0000_0000_0001};
        vecs[1] = '{pkt: 64'hA5A5_5A5A_0000_FFFF, pre_idle: 5, exp_word: 64'hA5A5_5A5A_0000_FFFF};
        vecs[2] = '{pkt: 64'h0123_4567_89AB_CDEF, pre_idle: 2, exp_word: 64'h0123_4567_89AB_CDEF};
        vecs[3] = '{pkt: 64'h0000_0000_0000_0000, pre_idle: 1, exp_word: 64'h0000_0000_0000_0000};

        // Reset held 10 cycles; valid raised during the last reset edge must not load.
        for (int i = 0; i < 10; i++) begin
            if (i == 9) begin
                sb.i_packet       = 64'hFFFF_0000_FFFF_0000;
                sb.i_packet_valid = 1'b1;
            end
            step();
        end
        check("reset_state", dbg_state, IDLE);
        rst_n             = 1'b1;
        sb.i_packet_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("no_load_in_reset", dbg_state, IDLE);

        // Table-driven single phases, each followed by the full dead time.
        for (int v = 0; v < 4; v++) begin
            send_phase(vecs[v].pkt, vecs[v].pre_idle);
            wait_word("vec_word_seen");
            check("vec_word", last_word, vecs[v].exp_word);
            for (int i = 0; i < GAP_UI; i++) step();
            check("vec_idle", dbg_state, IDLE);
        end

        // Back-to-back: data held valid behind the header loads with no bubble.
        sb.i_packet       = 64'hDEAD_BEEF_0123_4567;
        sb.i_packet_valid = 1'b1;
        wait_accept();
        sb.i_packet = 64'hFFFF_FFFF_FFFF_FFFF;
        fall_cyc = -1;
        rise_cyc = -1;
        prev_ce  = 1'b0;
        for (int n = 0; n < 3 * PERIOD && rise_cyc < 0; n++) begin
            step();
            if (sb.o_clk_en === 1'b1 && sb.i_packet_valid) sb.i_packet_valid = (load_edge < 0) || (model_pkt != 64'hFFFF_FFFF_FFFF_FFFF);
            if (prev_ce && sb.o_clk_en !== 1'b1 && fall_cyc < 0) fall_cyc = cyc - 1;
            if (!prev_ce && sb.o_clk_en === 1'b1 && fall_cyc >= 0) rise_cyc = cyc;
            prev_ce = (sb.o_clk_en === 1'b1);
        end
        sb.i_packet_valid = 1'b0;
        check("b2b_low_ui", rise_cyc - fall_cyc - 1, GAP_UI);
        wait_word("b2b_data_seen");
        check("b2b_data", last_word, 64'hFFFF_FFFF_FFFF_FFFF);
        for (int i = 0; i < GAP_UI; i++) step();

        // Valid with a different phase while shifting is ignored.
        send_phase(64'h1357_9BDF_2468_ACE0, 0);
        for (int i = 0; i < 9; i++) step();
        sb.i_packet       = 64'h0;
        sb.i_packet_valid = 1'b1;
        step();
        sb.i_packet_valid = 1'b0;
        wait_word("busy_word_seen");
        check("busy_word", last_word, 64'h1357_9BDF_2468_ACE0);
        for (int i = 0; i < GAP_UI; i++) step();

        // Reset in the middle of a phase drops it; the next phase starts from bit 0.
        send_phase(64'hCAFE_F00D_1234_5678, 0);
        for (int i = 0; i < 20; i++) step();
        async_reset(3);
        step();
        send_phase(64'h0F0F_0F0F_0F0F_0F0F, 1);
        wait_word("post_rst_word_seen");
        check("post_rst_word", last_word, 64'h0F0F_0F0F_0F0F_0F0F);
        for (int i = 0; i < GAP_UI; i++) step();

        // Random valid/data traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            sb.i_packet       = {$urandom, $urandom};
            sb.i_packet_valid = ($urandom_range(0, 3) == 0);
            step();
        end
        sb.i_packet_valid = 1'b0;
        for (int i = 0; i < PERIOD + 4; i++) step();
        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sb_tx_serializer.md
# sb_tx_serializer

Sideband transmit serializer, directly downstream of the sideband packet framing stage. It accepts one 64-bit framed phase (header or data) per handshake and shifts it out LSB-first on the single-bit sideband TX data lane, with a matching clock-enable for the forwarded sideband clock. It then enforces the mandatory 32-UI low dead time before raising `o_ser_done` so framing may present the next phase. One clock cycle equals one UI.

## Interface
- `PKT_W`, 64, width of one framed phase in bits/UI.
- `GAP_UI`, 32, number of idle low UI inserted after every phase.
- `i_clk`  in  1  sideband serializer clock; one cycle per UI.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_packet`  in  PKT_W  framed phase from framing (`o_framed_packet_phase`).
- `i_packet_valid`  in  1  phase on `i_packet` is valid (framing `o_packet_valid`).
- `o_ser_done`  out  1  serializer can accept a phase this cycle; drives framing `i_ser_done`.
- `o_txdata`  out  1  serial TX data bit.
- `o_clk_en`  out  1  enable for the forwarded TX sideband clock; high only while bits are being shifted.

## Operation
- States: IDLE, SHIFT, GAP.
- IDLE:
  - `o_ser_done`=1, `o_txdata`=0, `o_clk_en`=0.
  - Posedge with `i_packet_valid`=1: load `i_packet` into the shift register, clear the bit counter, go to SHIFT.
- SHIFT: lasts exactly PKT_W cycles.
  - `o_txdata` = shift_reg[0], registered; `o_clk_en`=1.
  - Shift right by one each cycle; the bit counter increments.
  - At count PKT_W-1, go to GAP and clear the gap counter.
  - `o_ser_done`=0 throughout.
- GAP: lasts exactly GAP_UI cycles.
  - `o_txdata`=0, `o_clk_en`=0.
  - `o_ser_done`=1 only in the final gap cycle (gap count = GAP_UI-1).
  - At that edge: if `i_packet_valid`=1, load and go straight to SHIFT (back-to-back, exactly GAP_UI low UI between phases); otherwise go to IDLE.
- `i_packet_valid` while `o_ser_done`=0 is ignored. Framing must hold the phase until it sees `o_ser_done`=1; no data is captured and no error is flagged.
- `i_packet` is sampled only on the load edge. Later changes have no effect on the phase in flight.
- Counters: bit counter is $clog2(PKT_W) bits (6 bits); gap counter is $clog2(GAP_UI) bits (5 bits). Both compare against terminal values and never wrap.

## Timing
- Reset values: state=IDLE, `o_ser_done`=1, `o_txdata`=0, `o_clk_en`=0, shift register = 0, counters = 0.
- Latency: load at edge N, then bit0 appears on `o_txdata` after edge N+1, and bit63 after edge N+64. All outputs are registered.
- `o_clk_en` is high for exactly PKT_W consecutive cycles per phase, aligned with the data bits.
- Phase period, back-to-back: PKT_W+GAP_UI = 96 cycles.
- `o_ser_done` returns high one cycle before the next possible load. A phase held valid by framing therefore starts with zero bubble after the gap.
- Reset mid-SHIFT or mid-GAP aborts immediately (asynchronous): outputs go to reset values and the partially sent phase is dropped.
- `i_packet_valid` asserted in the same cycle as reset release is not captured. Capture starts at the first posedge with `i_rst_n`=1.

## Structure
- Shared package `sb_pkg`:
  - constants `SB_PKT_W`=64 and `SB_GAP_UI`=32, used as the parameter defaults;
  - enum `sb_ser_state_e` {IDLE, SHIFT, GAP}.
- Single module, no sub-modules. The shift register, the two counters and the FSM are inline.

## Test plan
- Reset: hold `i_rst_n`=0 for 10 cycles → `o_ser_done`=1, `o_txdata`=0, `o_clk_en`=0.
- Single phase: `i_packet`=64'h8000_0000_0000_0001, one-cycle valid → `o_txdata`=1 at UI0, 0 for UI1..62, 1 at UI63; `o_clk_en` high 64 cycles; 32 low cycles follow; `o_ser_done`=1 only on the last gap cycle and afterwards.
- Back-to-back: framing holds header 64'hDEAD_BEEF_0123_4567 then data 64'hFFFF_FFFF_FFFF_FFFF → data bit0 starts exactly 32 cycles after header bit63; the data phase is 64 ones.
- Valid while busy: pulse `i_packet_valid` with 64'h0 at SHIFT cycle 10 → ignored, the original phase completes unchanged.
- Delayed valid: assert valid 5 cycles after IDLE is entered → load on that edge; serial output is correct with no extra gap.
- Reset mid-operation: assert `i_rst_n`=0 at SHIFT cycle 20 → outputs take reset values immediately; after release a new phase 64'h0F0F_0F0F_0F0F_0F0F serializes correctly from bit0.
